// File: rtl/alu_stage_pkg.sv
// Shared definitions for the execute stage: widths, ALU opcodes and the
// bit positions of the packed status word {Z,N,V}.
package alu_stage_pkg;

  localparam int unsigned N_W = 16;
  localparam int unsigned M_W = 2;

  typedef enum logic [M_W-1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_op_e;

  // Bit positions inside the packed status word {Z,N,V}.
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_stage_alu.sv
// Purely combinational ALU: four operations plus zero/negative/overflow flags.
import alu_stage_pkg::*;

module alu (
  input  logic [N_W-1:0] ain,
  input  logic [N_W-1:0] bin,
  input  logic [M_W-1:0] alu_op,
  output logic [N_W-1:0] result,
  output logic           z,
  output logic           n,
  output logic           v
);

  // Result selection and signed-overflow detection; carry-out is dropped.
  always_comb begin
    result = '0;
    v      = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        result = ain + bin;
        v      = (ain[N_W-1] == bin[N_W-1]) && (result[N_W-1] != ain[N_W-1]);
      end
      ALU_SUB: begin
        result = ain - bin;
        v      = (ain[N_W-1] != bin[N_W-1]) && (result[N_W-1] != ain[N_W-1]);
      end
      ALU_AND: result = ain & bin;
      ALU_NOT: result = ~bin;
      // An undefined opcode propagates X so enabled registers capture it.
      default: begin
        result = 'x;
        v      = 1'bx;
      end
    endcase
  end

  assign z = (result == '0);
  assign n = result[N_W-1];

endmodule

// File: rtl/alu_stage.sv
// Execute stage: operand selection, ALU, result register C with a valid bit,
// and the {Z,N,V} status register, each behind its own load enable.
import alu_stage_pkg::*;

module alu_stage (
  input  logic           clk,
  input  logic           reset,
  input  logic [N_W-1:0] a_in,
  input  logic [N_W-1:0] shift_out,
  input  logic [N_W-1:0] imm,
  input  logic           asel,
  input  logic           bsel,
  input  logic [M_W-1:0] alu_op,
  input  logic           loadc,
  input  logic           loads,
  output logic [N_W-1:0] c_out,
  output logic           c_valid,
  output logic           z_flag,
  output logic           n_flag,
  output logic           v_flag
);

  logic [N_W-1:0] ain;
  logic [N_W-1:0] bin;
  logic [N_W-1:0] result;
  logic           z;
  logic           n;
  logic           v;
  logic [2:0]     status;

  assign ain = asel ? '0  : a_in;
  assign bin = bsel ? imm : shift_out;

  alu u_alu (
    .ain    (ain),
    .bin    (bin),
    .alu_op (alu_op),
    .result (result),
    .z      (z),
    .n      (n),
    .v      (v)
  );

  // Result register C and its "loaded since reset" marker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_out   <= '0;
      c_valid <= 1'b0;
    end else if (loadc) begin
      c_out   <= result;
      c_valid <= 1'b1;
    end
  end

  // Status register, loaded independently of C from the same result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status <= '0;
    end else if (loads) begin
      status[FLAG_Z] <= z;
      status[FLAG_N] <= n;
      status[FLAG_V] <= v;
    end
  end

  assign z_flag = status[FLAG_Z];
  assign n_flag = status[FLAG_N];
  assign v_flag = status[FLAG_V];

endmodule

// File: tb/tb_alu_stage.sv
// Directed-vector bench for alu_stage with hand-computed expectations.
module tb_alu_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] a_in;
  logic [15:0] shift_out;
  logic [15:0] imm;
  logic        asel;
  logic        bsel;
  logic [1:0]  alu_op;
  logic        loadc;
  logic        loads;
  logic [15:0] c_out;
  logic        c_valid;
  logic        z_flag;
  logic        n_flag;
  logic        v_flag;

  int checks = 0;
  int errors = 0;

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  alu_stage dut (
    .clk       (clk),
    .reset     (reset),
    .a_in      (a_in),
    .shift_out (shift_out),
    .imm       (imm),
    .asel      (asel),
    .bsel      (bsel),
    .alu_op    (alu_op),
    .loadc     (loadc),
    .loads     (loads),
    .c_out     (c_out),
    .c_valid   (c_valid),
    .z_flag    (z_flag),
    .n_flag    (n_flag),
    .v_flag    (v_flag)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Compare every output against expected C, valid and {Z,N,V}.
  task automatic check_all(input string tag, input logic [15:0] c, input logic vld,
                           input logic [2:0] znv);
    check({tag, ".c"}, c_out, c);
    check({tag, ".valid"}, {15'd0, c_valid}, {15'd0, vld});
    check({tag, ".znv"}, {13'd0, z_flag, n_flag, v_flag}, {13'd0, znv});
  endtask

  // Advance one rising edge, then sample/drive 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] s, input logic [15:0] i,
                       input logic as, input logic bs, input logic [1:0] op,
                       input logic lc, input logic ls);
    a_in = a; shift_out = s; imm = i; asel = as; bsel = bs;
    alu_op = op; loadc = lc; loads = ls;
  endtask

  initial begin
    // Reset with enables high and nonzero operands.
    reset = 1'b1;
    drive(16'h5555, 16'h1111, 16'h2222, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    #1;
    check_all("reset0", 16'h0000, 1'b0, 3'b000);
    tick();
    check_all("reset1", 16'h0000, 1'b0, 3'b000);
    tick();
    check_all("reset2", 16'h0000, 1'b0, 3'b000);
    reset = 1'b0;

    // ADD overflow: 7FFF + 0001 = 8000.
    drive(16'h7FFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    tick();
    check_all("add_ovf", 16'h8000, 1'b1, 3'b011);

    // SUB to zero via immediate, flags only; C keeps 8000.
    drive(16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1);
    tick();
    check_all("sub_zero", 16'h8000, 1'b1, 3'b100);

    // SUB overflow: 8000 - 0001 = 7FFF.
    drive(16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1);
    tick();
    check_all("sub_ovf", 16'h7FFF, 1'b1, 3'b001);

    // asel forces A to zero: 0 & 00FF = 0.
    drive(16'hFFFF, 16'h00FF, 16'h0000, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1);
    tick();
    check_all("and_asel", 16'h0000, 1'b1, 3'b100);

    // NOT ignores A: ~00FF = FF00.
    drive(16'h1234, 16'h00FF, 16'h0000, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1);
    tick();
    check_all("not", 16'hFF00, 1'b1, 3'b010);

    // AND with live A: F0F0 & 3C3C = 3030.
    drive(16'hF0F0, 16'h3C3C, 16'h0000, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1);
    tick();
    check_all("and", 16'h3030, 1'b1, 3'b000);

    // ADD negative overflow: 8000 + FFFF = 7FFF.
    drive(16'h8000, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1);
    tick();
    check_all("add_novf", 16'h7FFF, 1'b1, 3'b001);

    // SUB negative result without overflow: 5 - 7 = FFFE.
    drive(16'h0005, 16'h0007, 16'h0000, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1);
    tick();
    check_all("sub_neg", 16'hFFFE, 1'b1, 3'b010);

    // C only: 0003 + 0004 = 0007; flags keep {0,1,0}.
    drive(16'h0003, 16'h0000, 16'h0004, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
    tick();
    check_all("c_only", 16'h0007, 1'b1, 3'b010);

    // Hold: enables low, operands changing every cycle.
    for (int k = 0; k < 5; k++) begin
      drive(16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)),
            16'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0, 1'b0);
      tick();
      check_all("hold", 16'h0007, 1'b1, 3'b010);
    end

    // Reset pulse between edges clears state before the next edge.
    #2;
    reset = 1'b1;
    #1;
    check_all("async_rst", 16'h0000, 1'b0, 3'b000);
    reset = 1'b0;
    tick();
    check_all("post_rst", 16'h0000, 1'b0, 3'b000);

    // First load after reset: FFFF + 0001 = 0000, carry dropped.
    drive(16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    tick();
    check_all("add_wrap", 16'h0000, 1'b1, 3'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
